// File: rtl/rgb2ycc_if.sv
// Pixel stream bundle for rgb2ycc: RGB input side and YCbCr output side.
// master drives pixels in; slave is the converter.
interface rgb2ycc_if #(parameter int COLORDEPTH = 8);
    logic [3*COLORDEPTH-1:0] rgb_i;
    logic                    dv_i;
    logic                    line_end_i;
    logic [1:0]              mode_i;
    logic [3*COLORDEPTH-1:0] ycc_o;
    logic                    dv_o;
    logic                    line_end_o;

    modport master (
        output rgb_i, dv_i, line_end_i, mode_i,
        input  ycc_o, dv_o, line_end_o
    );

    modport slave (
        input  rgb_i, dv_i, line_end_i, mode_i,
        output ycc_o, dv_o, line_end_o
    );
endinterface

// File: rtl/rgb2ycc.sv
// RGB to YCbCr converter, 3-stage free-running pipeline (multiply, sum, clamp/format).
// Optional macro RGB2YCC_ROUND_EN selects round-half-up instead of floor truncation.
module rgb2ycc #(
    parameter int COLORDEPTH = 8
) (
    input logic       clk,
    input logic       rst,
    rgb2ycc_if.slave  bus
);
    localparam int CD = COLORDEPTH;
    localparam int W  = CD + 10;
    localparam logic [CD-1:0]       OFS   = {1'b1, {(CD-1){1'b0}}};
    localparam logic [CD-1:0]       MAXV  = {CD{1'b1}};
    localparam logic signed [W-1:0] OFS_W = {{(W-CD){1'b0}}, OFS};

`ifdef RGB2YCC_ROUND_EN
    localparam logic signed [W-1:0] RND     = W'(128);
    localparam logic [CD:0]         AVG_RND = {{CD{1'b0}}, 1'b1};
`else
    localparam logic signed [W-1:0] RND     = '0;
    localparam logic [CD:0]         AVG_RND = '0;
`endif

    typedef enum logic [1:0] {
        MODE_GRAY = 2'b00,
        MODE_444  = 2'b01,
        MODE_422  = 2'b10
    } mode_t;

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_GRAY;
            2'b10:   return MODE_422;
            default: return MODE_444;
        endcase
    endfunction

    function automatic logic signed [W-1:0] mul(input logic [CD-1:0] c, input logic signed [9:0] k);
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        a = {{(W-CD){1'b0}}, c};
        b = {{(W-10){k[9]}}, k};
        return a * b;
    endfunction

    function automatic logic [CD-1:0] clamp(input logic signed [W-1:0] v);
        if (v[W-1])
            return '0;
        else if (|v[W-2:CD])
            return MAXV;
        else
            return v[CD-1:0];
    endfunction

    logic [CD-1:0] r;
    logic [CD-1:0] g;
    logic [CD-1:0] b;
    assign r = bus.rgb_i[3*CD-1:2*CD];
    assign g = bus.rgb_i[2*CD-1:CD];
    assign b = bus.rgb_i[CD-1:0];

    // Line tracking: mode and 4:2:2 phase are resolved per pixel at the input.
    mode_t mode_q;
    mode_t pix_mode;
    logic  phase_q;
    logic  pix_phase;
    logic  first_q;

    always_comb begin
        pix_mode  = first_q ? decode_mode(bus.mode_i) : mode_q;
        pix_phase = first_q ? 1'b0 : phase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_444;
            phase_q <= 1'b0;
            first_q <= 1'b1;
        end else if (bus.dv_i) begin
            mode_q  <= pix_mode;
            phase_q <= ~pix_phase;
            first_q <= bus.line_end_i;
        end
    end

    logic signed [W-1:0] prod [9];

    always_comb begin
        prod[0] = mul(r,  10'sd72);
        prod[1] = mul(g,  10'sd144);
        prod[2] = mul(b,  10'sd30);
        prod[3] = mul(r, -10'sd38);
        prod[4] = mul(g, -10'sd74);
        prod[5] = mul(b,  10'sd112);
        prod[6] = mul(r,  10'sd112);
        prod[7] = mul(g, -10'sd94);
        prod[8] = mul(b, -10'sd18);
    end

    logic                s1_dv;
    logic                s1_le;
    logic                s1_phase;
    mode_t               s1_mode;
    logic signed [W-1:0] p1 [9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_dv    <= 1'b0;
            s1_le    <= 1'b0;
            s1_phase <= 1'b0;
            s1_mode  <= MODE_444;
            p1       <= '{default: '0};
        end else begin
            s1_dv    <= bus.dv_i;
            s1_le    <= bus.dv_i & bus.line_end_i;
            s1_phase <= pix_phase;
            s1_mode  <= pix_mode;
            p1       <= prod;
        end
    end

    logic signed [W-1:0] y_sum;
    logic signed [W-1:0] cb_sum;
    logic signed [W-1:0] cr_sum;

    always_comb begin
        y_sum  = p1[0] + p1[1] + p1[2] + RND;
        cb_sum = p1[3] + p1[4] + p1[5] + RND;
        cr_sum = p1[6] + p1[7] + p1[8] + RND;
    end

    logic                s2_dv;
    logic                s2_le;
    logic                s2_phase;
    mode_t               s2_mode;
    logic signed [W-1:0] y2;
    logic signed [W-1:0] cb2;
    logic signed [W-1:0] cr2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_dv    <= 1'b0;
            s2_le    <= 1'b0;
            s2_phase <= 1'b0;
            s2_mode  <= MODE_444;
            y2       <= '0;
            cb2      <= '0;
            cr2      <= '0;
        end else begin
            s2_dv    <= s1_dv;
            s2_le    <= s1_le;
            s2_phase <= s1_phase;
            s2_mode  <= s1_mode;
            y2       <= y_sum >>> 8;
            cb2      <= (cb_sum >>> 8) + OFS_W;
            cr2      <= (cr_sum >>> 8) + OFS_W;
        end
    end

    logic [CD-1:0] y3;
    logic [CD-1:0] cb3;
    logic [CD-1:0] cr3;
    logic [CD-1:0] cr_store;
    logic [CD:0]   avg_sum;
    logic [CD-1:0] f1;
    logic [CD-1:0] f2;

    // In 4:2:2 the odd pixel carries the averaged Cr of the pair; F2 is unused.
    always_comb begin
        y3      = clamp(y2);
        cb3     = clamp(cb2);
        cr3     = clamp(cr2);
        avg_sum = {1'b0, cr_store} + {1'b0, cr3} + AVG_RND;
        f1      = OFS;
        f2      = OFS;
        case (s2_mode)
            MODE_444: begin
                f1 = cb3;
                f2 = cr3;
            end
            MODE_422: begin
                f1 = s2_phase ? avg_sum[CD:1] : cb3;
                f2 = '0;
            end
            default: begin
                f1 = OFS;
                f2 = OFS;
            end
        endcase
    end

    logic [3*CD-1:0] ycc_q;
    logic            dv_q;
    logic            le_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ycc_q    <= '0;
            dv_q     <= 1'b0;
            le_q     <= 1'b0;
            cr_store <= '0;
        end else begin
            dv_q <= s2_dv;
            le_q <= s2_le;
            if (s2_dv) begin
                ycc_q <= {y3, f1, f2};
                if (s2_mode == MODE_422 && !s2_phase)
                    cr_store <= cr3;
            end
        end
    end

    assign bus.ycc_o      = ycc_q;
    assign bus.dv_o       = dv_q;
    assign bus.line_end_o = le_q;

endmodule

// File: doc/rgb2ycc.md
RGB2YCC -- requirements
Module: rgb2ycc

Interface
REQ-001 Parameter: COLORDEPTH, default 8, bits per colour component (legal 4..12).
REQ-002 clk  input  1  clock; all registers sample on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rgb_i  input  3*COLORDEPTH  pixel {R,G,B}, R in MSBs.
REQ-005 dv_i  input  1  rgb_i valid this cycle.
REQ-006 line_end_i  input  1  qualified by dv_i; marks last pixel of a line.
REQ-007 mode_i  input  2  00 gray, 01 YCbCr 4:4:4, 10 YCbCr 4:2:2, 11 treated as 01.
REQ-008 ycc_o  output  3*COLORDEPTH  {Y,F1,F2}, Y in MSBs.
REQ-009 dv_o  output  1  ycc_o valid.
REQ-010 line_end_o  output  1  line_end_i delayed with its pixel.

Function
REQ-011 Coefficients SHALL be 8 fractional bits: Y=(72R+144G+30B)/256; Cb=OFS+(-38R-74G+112B)/256; Cr=OFS+(112R-94G-18B)/256; OFS=2^(COLORDEPTH-1).
REQ-012 Products and sums SHALL be signed, full width (COLORDEPTH+10 bits); division is an arithmetic shift right by 8 (floor).
REQ-013 Each result SHALL be clamped to [0, 2^COLORDEPTH-1] before output.
REQ-014 Pipeline SHALL be exactly 3 stages: multiply, sum, clamp/format; dv_o, line_end_o, ycc_o appear 3 cycles after the dv_i cycle.
REQ-015 Pipeline SHALL be free-running; gaps in dv_i propagate as dv_o=0 gaps; no stall input exists.
REQ-016 When dv_o=0, ycc_o SHALL hold its last valid value.
REQ-017 Active mode SHALL be latched from mode_i on the first valid pixel of each line (after reset or after a pixel with line_end_i=1) and held until line end.
REQ-018 Gray mode: F1=F2=OFS.
REQ-019 4:4:4 mode: F1=Cb, F2=Cr of the same pixel.
REQ-020 4:2:2 mode: a phase bit, cleared at line start, toggles on every valid pixel.
REQ-021 4:2:2 even phase: F1=Cb of that pixel; the pixel's Cr is stored.
REQ-022 4:2:2 odd phase: F1=floor((Cr_stored+Cr_current)/2); F2=0 in both phases.
REQ-023 Line with odd pixel count: last (even) pixel emits Cb only; stored Cr discarded at line_end.
REQ-024 dv_i=1 with line_end_i=1 on a single-pixel line SHALL emit an even-phase pixel; the next valid pixel starts a new line at even phase.

Reset
REQ-025 On rst=1, dv_o=0, line_end_o=0, ycc_o=0 immediately, with no clock required.
REQ-026 Reset SHALL clear all pipeline valid bits, the phase bit, stored Cr, and the latched mode (to 01).
REQ-027 Pixels in flight at reset SHALL be discarded; the first dv_o after release corresponds to a pixel accepted after release.

Configuration
REQ-028 Macro RGB2YCC_ROUND_EN defined: add 128 before each shift in REQ-012 (round half up); the 4:2:2 average adds 1 before halving.
REQ-029 Macro RGB2YCC_ROUND_EN undefined: floor truncation throughout; latency and interface unchanged.

Verification (COLORDEPTH=8, RGB2YCC_ROUND_EN undefined unless stated)
REQ-030 mode 01, rgb_i=FFFFFF single dv_i pulse -> 3 cycles later dv_o=1, ycc_o=F58080.
REQ-031 mode 01, rgb_i=FF0000 -> ycc_o=475AEF; with RGB2YCC_ROUND_EN -> ycc_o=485AF0.
REQ-032 mode 10, pixels 0000FF then FF0000 -> outputs {1D,EF,00} then {47,AE,00}.
REQ-033 mode 10, 3-pixel line then next line pixel 0000FF -> next-line first output F1=EF (even phase restored); line_end_o high on the 3rd output only.
REQ-034 mode switched 01->00 mid-line -> remaining pixels of the line stay 4:4:4; next line outputs F1=F2=80.
REQ-035 rst asserted with 2 pixels in flight -> dv_o=0 in the same cycle, no dv_o pulse until 3 cycles after the first post-release dv_i.
